pin_input_filter: RTL and testbench

PIN_INPUT_FILTER -- requirements
Module: pin_input_filter

---
 rtl/pin_input_filter.sv | 97 +++++++++
 tb/tb_pin_input_filter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_input_filter.sv
// rtl/pin_input_filter.sv - synchronize, debounce and change-flag the FPGA input pins
// Debounced levels and sticky change flags are packed per byte for the MCU bus block.
module pin_input_filter #(
  parameter int PINS_CONT       = 132,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 CLK50,
  input  logic                 rst,
  input  logic [PINS_CONT-1:0] io_in,
  output logic [0:16][7:0]     input_pins_state,
  output logic [0:16][7:0]     change_flags,
  input  logic                 clr_valid,
  input  logic [4:0]           clr_addr,
  output logic                 irq
);

  localparam int NBYTES = 17;
  localparam int NBITS  = NBYTES * 8;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("pin_input_filter: DEBOUNCE_CYCLES out of range 1..255");
  end
  if (PINS_CONT < 1 || PINS_CONT > NBITS) begin : g_bad_pins
    $error("pin_input_filter: PINS_CONT must fit in 17 bytes");
  end

  logic [PINS_CONT-1:0] sync1;
  logic [PINS_CONT-1:0] sync2;
  logic [PINS_CONT-1:0] stable;
  logic [PINS_CONT-1:0] flag;
  logic [CW-1:0]        cnt [PINS_CONT];

  logic [PINS_CONT-1:0] differ;
  logic [PINS_CONT-1:0] accept;
  logic [PINS_CONT-1:0] clr_mask;
  logic                 clr_hit;

  logic [NBITS-1:0]     stable_pad;
  logic [NBITS-1:0]     flag_pad;

  always_comb begin
    clr_hit  = clr_valid && (clr_addr <= 5'(NBYTES - 1));
    differ   = sync2 ^ stable;
    accept   = '0;
    clr_mask = '0;
    for (int i = 0; i < PINS_CONT; i++) begin
      accept[i]   = differ[i] && (cnt[i] == CNT_LAST);
      clr_mask[i] = clr_hit && (clr_addr == 5'(i / 8));
    end
  end

  // A new acceptance is OR-ed in after the clear mask so a same-edge set wins.
  always_ff @(posedge CLK50) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      flag   <= '0;
      irq    <= 1'b0;
      for (int i = 0; i < PINS_CONT; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= io_in;
      sync2  <= sync1;
      stable <= stable ^ accept;
      flag   <= (flag & ~clr_mask) | accept;
      irq    <= |flag;
      for (int i = 0; i < PINS_CONT; i++) begin
        if (!differ[i] || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Bits beyond PINS_CONT are tied to zero through the padded vectors.
  always_comb begin
    stable_pad                 = '0;
    flag_pad                   = '0;
    stable_pad[PINS_CONT-1:0]  = stable;
    flag_pad[PINS_CONT-1:0]    = flag;
    input_pins_state           = '0;
    change_flags               = '0;
    for (int k = 0; k < NBYTES; k++) begin
      for (int b = 0; b < 8; b++) begin
        input_pins_state[k][b] = stable_pad[8*k+b];
        change_flags[k][b]     = flag_pad[8*k+b];
      end
    end
  end

endmodule

// File: tb/tb_pin_input_filter.sv
// tb/tb_pin_input_filter.sv - self-checking bench for pin_input_filter
// Directed table and corner sequences plus random traffic against a window-based reference model.
module tb_pin_input_filter;

  localparam int P    = 132;
  localparam int D    = 4;
  localparam int NB   = 136;
  localparam int HMAX = 8192;

  logic             clk = 1'b0;
  logic             rst;
  logic [P-1:0]     io;
  logic             cv;
  logic [4:0]       ca;
  logic [0:16][7:0] st;
  logic [0:16][7:0] fl;
  logic             irq;

  always #5 clk = ~clk;

  pin_input_filter #(.PINS_CONT(P), .DEBOUNCE_CYCLES(D)) dut (
    .CLK50            (clk),
    .rst              (rst),
    .io_in            (io),
    .input_pins_state (st),
    .change_flags     (fl),
    .clr_valid        (cv),
    .clr_addr         (ca),
    .irq              (irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: samp[e] is the io_in value captured at edge e. A pin is accepted at
  // edge e when the D samples taken at edges e-D-1 .. e-2 all differ from its level.
  logic [P-1:0] samp [0:HMAX-1];
  logic [P-1:0] st_m;
  logic [P-1:0] fl_m;
  logic         irq_m;
  int           ecnt = 0;

  typedef struct {
    bit r;
    bit p0;
    bit p9;
    bit s0;
    bit f0;
    bit s9;
    bit q;
  } vec_t;
  vec_t tv [18];

  function automatic logic [NB-1:0] flat(input logic [0:16][7:0] a);
    logic [NB-1:0] r;
    for (int k = 0; k < 17; k++)
      for (int b = 0; b < 8; b++)
        r[8*k+b] = a[k][b];
    return r;
  endfunction

  function automatic logic [NB-1:0] pad(input logic [P-1:0] v);
    logic [NB-1:0] r;
    r = '0;
    r[P-1:0] = v;
    return r;
  endfunction

  task automatic chkv(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic model_update();
    logic [P-1:0] acc;
    logic         irq_new;
    logic         all_diff;
    if (ecnt >= HMAX - 1) begin
      $display("FAIL history_budget: got %0d edges want < %0d", ecnt, HMAX - 1);
      $fatal(1, "history exhausted");
    end
    ecnt++;
    if (rst) begin
      samp[ecnt]     = '0;
      samp[ecnt - 1] = '0;
      st_m  = '0;
      fl_m  = '0;
      irq_m = 1'b0;
    end else begin
      samp[ecnt] = io;
      irq_new    = |fl_m;
      acc        = '0;
      if (ecnt - D - 1 >= 0) begin
        for (int p = 0; p < P; p++) begin
          all_diff = 1'b1;
          for (int k = 2; k <= D + 1; k++)
            if (samp[ecnt - k][p] == st_m[p]) all_diff = 1'b0;
          acc[p] = all_diff;
        end
      end
      if (cv && ca <= 5'd16)
        for (int p = 0; p < P; p++)
          if (p / 8 == int'(ca)) fl_m[p] = 1'b0;
      fl_m  = fl_m | acc;
      st_m  = st_m ^ acc;
      irq_m = irq_new;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chkv("model_state", flat(st), pad(st_m));
    chkv("model_flags", flat(fl), pad(fl_m));
    chk1("model_irq", irq, irq_m);
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) samp[i] = '0;
    st_m  = '0;
    fl_m  = '0;
    irq_m = 1'b0;
    rst = 1'b1;
    io  = '0;
    cv  = 1'b0;
    ca  = 5'd0;

    // Row i is applied before edge i+1: pin 0 rises before edge 10, pin 9 pulses edges 3..5.
    for (int i = 0; i < 18; i++) begin
      tv[i].r  = (i == 0);
      tv[i].p0 = (i + 1 >= 10);
      tv[i].p9 = (i + 1 >= 3) && (i + 1 <= 5);
      tv[i].s0 = (i + 1 >= 15);
      tv[i].f0 = (i + 1 >= 15);
      tv[i].s9 = 1'b0;
      tv[i].q  = (i + 1 >= 16);
    end

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      rst   = tv[i].r;
      io    = '0;
      io[0] = tv[i].p0;
      io[9] = tv[i].p9;
      step();
      if (tv[i].r) begin
        chkv("reset_state", flat(st), '0);
        chkv("reset_flags", flat(fl), '0);
        chk1("reset_irq", irq, 1'b0);
      end
      chk1("tbl_state0", st[0][0], tv[i].s0);
      chk1("tbl_flag0", fl[0][0], tv[i].f0);
      chk1("tbl_state9", st[1][1], tv[i].s9);
      chk1("tbl_flag9", fl[1][1], 1'b0);
      chk1("tbl_irq", irq, tv[i].q);
    end

    // Flags in bytes 1 and 16, then clear them one byte at a time.
    io[8]   = 1'b1;
    io[128] = 1'b1;
    cv = 1'b1; ca = 5'd0;
    step();
    cv = 1'b0;
    repeat (7) step();
    chk8("set_b1", fl[1], 8'h01);
    chk8("set_b16", fl[16], 8'h01);
    cv = 1'b1; ca = 5'd1;
    step();
    chk8("clr1_b1", fl[1], 8'h00);
    chk8("clr1_b16", fl[16], 8'h01);
    chk1("clr1_irq", irq, 1'b1);
    cv = 1'b0;
    step();
    chk1("clr1_irq_hold", irq, 1'b1);
    cv = 1'b1; ca = 5'd16;
    step();
    chk8("clr16_b16", fl[16], 8'h00);
    chk1("clr16_irq_lag", irq, 1'b1);
    cv = 1'b0;
    step();
    chk1("clr16_irq", irq, 1'b0);

    // Out-of-range clear addresses are ignored.
    io[8] = 1'b0;
    repeat (6) step();
    chk8("fall_b1", fl[1], 8'h01);
    cv = 1'b1; ca = 5'd20;
    step();
    chkv("clr20_flags", flat(fl), pad(P'(1) << 8));
    ca = 5'd17;
    step();
    chkv("clr17_flags", flat(fl), pad(P'(1) << 8));
    cv = 1'b0;

    // Acceptance on pin 130 lands on the same edge as a clear of byte 16.
    io[130] = 1'b1;
    repeat (5) step();
    chk1("p130_early", st[16][2], 1'b0);
    cv = 1'b1; ca = 5'd16;
    step();
    chk1("p130_set_wins", fl[16][2], 1'b1);
    chk1("p130_state", st[16][2], 1'b1);
    chk8("pad_flags", {4'h0, fl[16][7:4]}, 8'h00);
    chk8("pad_state", {4'h0, st[16][7:4]}, 8'h00);
    cv = 1'b0;
    step();

    // Reset two cycles into a debounce of pin 5, then reacquire with the pin held high.
    io[5] = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    chkv("rst_mid_state", flat(st), '0);
    chkv("rst_mid_flags", flat(fl), '0);
    chk1("rst_mid_irq", irq, 1'b0);
    rst = 1'b0;
    repeat (D + 1) step();
    chk1("reacq_early", st[0][5], 1'b0);
    step();
    chk1("reacq_state", st[0][5], 1'b1);
    chk1("reacq_flag", fl[0][5], 1'b1);

    // Random traffic, denser on pins 0..15 so short pulses are common there.
    repeat (2500) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int t = 0; t < int'($urandom_range(0, 3)); t++) begin
        int idx;
        idx = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, P - 1));
        io[idx] = ~io[idx];
      end
      cv = ($urandom_range(0, 3) == 0);
      ca = 5'($urandom_range(0, 20));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
